serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_pkg.sv | 18 +
 rtl/serial_adder_ctrl_carry_ff.sv | 26 ++
 rtl/serial_adder_ctrl.sv | 162 ++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding, default operand width and the carry majority helper.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SA_WIDTH = 8;
  localparam int SA_CNT_W = $clog2(SA_WIDTH);

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_carry_ff.sv
// Single-bit carry storage for the serial adder: async active-low clear,
// loads i_d when i_load is high, otherwise holds.
module carry_ff (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  // carry flop with load enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= 1'b0;
    end else if (i_load) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: captures a, b, cin on start and adds one bit per cycle,
// LSB first, publishing sum/cout on the final bit and pulsing done once.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic             w_carry;
  logic             w_s;
  logic             w_maj;
  logic             w_accept;
  logic             w_last;
  logic             w_carry_ld;
  logic             w_carry_d;
  logic             w_busy_d;
  logic             w_done_d;

  // per-bit full-adder terms and carry flop load control
  always_comb begin
    w_accept   = (r_state == IDLE) && start;
    w_s        = r_a_sr[0] ^ r_b_sr[0] ^ w_carry;
    w_maj      = majority(r_a_sr[0], r_b_sr[0], w_carry);
    w_last     = (r_cnt == CW'(WIDTH - 1));
    w_carry_ld = w_accept || (r_state == RUN);
    if (w_accept) begin
      w_carry_d = cin;
    end else begin
      w_carry_d = w_maj;
    end
  end

  carry_ff u_carry_ff (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_carry_ld),
    .i_d    (w_carry_d),
    .o_q    (w_carry)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // status outputs are decoded from the next state so they register in step with it
  always_comb begin
    w_busy_d = 1'b0;
    w_done_d = 1'b0;
    case (w_state_nxt)
      RUN:     w_busy_d = 1'b1;
      DONE:    w_done_d = 1'b1;
      default: begin
        w_busy_d = 1'b0;
        w_done_d = 1'b0;
      end
    endcase
  end

  // registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_d;
      r_done <= w_done_d;
    end
  end

  // operand/sum shift registers, bit counter and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_cnt  <= '0;
          end
        end
        RUN: begin
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
          r_cnt    <= r_cnt + CW'(1);
          // result is published straight from the shift path, not one cycle later
          if (w_last) begin
            r_sum  <= {w_s, r_sum_sr[WIDTH-1:1]};
            r_cout <= w_maj;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): a timeline model predicts
// busy/done/sum/cout each cycle and a queue holds expected results per accepted start.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic         cout;
  logic [W-1:0] sum;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           done_cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           done_hist[$];
  int           cyc       = 0;
  int           acc       = 0;
  bit           pend      = 1'b0;
  bit           was_pend  = 1'b0;
  logic [W:0]   pend_res  = '0;
  logic [W-1:0] last_sum  = '0;
  logic         last_cout = 1'b0;
  logic         exp_busy  = 1'b0;
  logic         exp_done  = 1'b0;
  int           checks    = 0;
  int           failures  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference timeline: an accepted start at edge k finishes at edge k+W, is free again at k+W+2
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      = 1'b0;
      last_sum  = '0;
      last_cout = 1'b0;
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      sb_q.delete();
    end else begin
      cyc      = cyc + 1;
      was_pend = pend;
      if (!was_pend && start) begin
        acc      = cyc;
        pend     = 1'b1;
        pend_res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        sb_q.push_back('{pend_res[W-1:0], pend_res[W], cyc + W});
      end else if (was_pend && cyc == acc + W) begin
        last_sum  = pend_res[W-1:0];
        last_cout = pend_res[W];
      end else if (was_pend && cyc == acc + W + 1) begin
        pend = 1'b0;
      end
      exp_busy = pend && (cyc < acc + W);
      exp_done = pend && (cyc == acc + W);
    end
  end

  // Monitor: per-cycle output checks plus scoreboard pop on every done pulse
  always @(negedge clk) begin
    exp_t e;
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("sum_hold", 32'(sum), 32'(last_sum));
    chk("cout_hold", 32'(cout), 32'(last_cout));
    if (rst && done) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        chk("sb_sum", 32'(sum), 32'(e.s));
        chk("sb_cout", 32'(cout), 32'(e.c));
        chk("sb_latency", 32'(cyc), 32'(e.done_cyc));
        done_hist.push_back(cyc);
      end
    end
  end

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    a     = ta;
    b     = tb_v;
    cin   = tc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    repeat (W + 2) @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    rst = 1'b1;
    @(negedge clk);

    op(8'h5A, 8'h3C, 1'b0);
    chk("5a_3c_sum", 32'(sum), 32'h96);
    chk("5a_3c_cout", 32'(cout), 32'(0));
    op(8'hFF, 8'h01, 1'b0);
    chk("ff_01_sum", 32'(sum), 32'h00);
    chk("ff_01_cout", 32'(cout), 32'(1));
    op(8'hFF, 8'hFF, 1'b1);
    chk("ff_ff_c_sum", 32'(sum), 32'hFF);
    chk("ff_ff_c_cout", 32'(cout), 32'(1));

    // start held high with operands churning every cycle
    done_hist.delete();
    start = 1'b1;
    repeat (32) begin
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);
    chk("b2b_count", 32'(done_hist.size()), 32'(4));
    for (int i = 1; i < done_hist.size(); i++) begin
      chk("b2b_gap", 32'(done_hist[i] - done_hist[i-1]), 32'(W + 2));
    end

    // reset after the 4th RUN edge
    a     = 8'h5A;
    b     = 8'h3C;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_sum", 32'(sum), 32'(0));
    chk("abort_cout", 32'(cout), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    op(8'h01, 8'h02, 1'b1);
    chk("post_rst_sum", 32'(sum), 32'h04);
    chk("post_rst_cout", 32'(cout), 32'(0));

    // previous result holds through a new operation
    op(8'h5A, 8'h3C, 1'b0);
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_mid_sum", 32'(sum), 32'h96);
    repeat (W) @(negedge clk);
    chk("hold_new_sum", 32'(sum), 32'h00);

    // random traffic
    repeat (400) begin
      start = ($urandom_range(0, 3) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
